// File: rtl/data_ctrl_dm_pkg.sv
// -----------------------------------------------------------------------------
// data_ctrl_dm_pkg
// Shared constants and helpers for the four-core cluster data memory.
//   DEPTH / AW    : number of 16-bit words and the internal index width
//   DW            : data word width
//   NUM_LANES     : one read port and one write lane per core
//   init_word()   : reset image (two interleaved 4x2 operand matrices)
//   addr_in_range : true when a full 16-bit address selects a real word
// -----------------------------------------------------------------------------
package data_ctrl_dm_pkg;

  localparam int unsigned DEPTH     = 64;
  localparam int unsigned AW        = $clog2(DEPTH);
  localparam int unsigned DW        = 16;
  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned LANE_W    = $clog2(NUM_LANES);

  typedef logic [DW-1:0]     word_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // Reset contents. M1 occupies columns 0/1 of rows 0,8,16,24; M2 occupies
  // columns 4/5 of rows 0,8,16,24, so the matmul program can stride by 8.
  function automatic word_t init_word(input int unsigned addr);
    word_t w;
    case (addr)
      0:       w = 16'd1;
      1:       w = 16'd5;
      8:       w = 16'd2;
      9:       w = 16'd6;
      16:      w = 16'd3;
      17:      w = 16'd7;
      24:      w = 16'd4;
      25:      w = 16'd8;
      4:       w = 16'd1;
      5:       w = 16'd2;
      12:      w = 16'd5;
      13:      w = 16'd6;
      20:      w = 16'd9;
      21:      w = 16'd10;
      28:      w = 16'd13;
      29:      w = 16'd14;
      default: w = '0;
    endcase
    return w;
  endfunction

  // Upper address bits must be zero; the compare covers any DEPTH, not just
  // powers of two.
  function automatic logic addr_in_range(input addr_t addr);
    return 32'(addr) < DEPTH;
  endfunction

endpackage

// File: rtl/data_ctrl_dm_if.sv
// -----------------------------------------------------------------------------
// data_ctrl_dm_if
// Bundles the per-core load/store signals of the shared data memory.
//   MEMWRITE       : common write strobe
//   MR[3:0]        : per-core read enables (bit i serves core i+1)
//   MADDR1..4      : per-core word addresses
//   DATAIN[63:0]   : write data, lane i in bits [16i+15:16i]
//   DOUT1..4       : per-core read data
// master = the cores (drive requests), slave = the memory.
// -----------------------------------------------------------------------------
interface data_ctrl_dm_if;

  logic        MEMWRITE;
  logic [3:0]  MR;
  logic [15:0] MADDR1;
  logic [15:0] MADDR2;
  logic [15:0] MADDR3;
  logic [15:0] MADDR4;
  logic [63:0] DATAIN;
  logic [15:0] DOUT1;
  logic [15:0] DOUT2;
  logic [15:0] DOUT3;
  logic [15:0] DOUT4;

  modport master (
    output MEMWRITE, MR, MADDR1, MADDR2, MADDR3, MADDR4, DATAIN,
    input  DOUT1, DOUT2, DOUT3, DOUT4
  );

  modport slave (
    input  MEMWRITE, MR, MADDR1, MADDR2, MADDR3, MADDR4, DATAIN,
    output DOUT1, DOUT2, DOUT3, DOUT4
  );

endinterface

// File: rtl/data_read_port.sv
// -----------------------------------------------------------------------------
// data_read_port
// One core's read port. The shared array read (word_i) is indexed only by
// the low address bits, so this block qualifies it with the read enable and
// the full-width range check.
//   addr_i   : full 16-bit word address from the core
//   rd_en_i  : read enable for this core
//   word_i   : array word at addr_i[AW-1:0]
//   dout_o   : read data, zero when disabled or out of range
// -----------------------------------------------------------------------------
module data_read_port
  import data_ctrl_dm_pkg::*;
(
  input  addr_t addr_i,
  input  logic  rd_en_i,
  input  word_t word_i,
  output word_t dout_o
);

  always_comb begin
    dout_o = '0;
    if (rd_en_i && addr_in_range(addr_i)) begin
      dout_o = word_i;
    end
  end

endmodule

// File: rtl/data_ctrl_dm.sv
// -----------------------------------------------------------------------------
// data_ctrl_dm
// Shared DEPTH x 16 data memory for a four-core cluster. Four independent
// combinational read ports and four write lanes sharing one strobe.
//   clk    : system clock, writes land on the rising edge
//   rst_n  : asynchronous active-low reset, reloads the operand image
//   bus    : data_ctrl_dm_if.slave (MEMWRITE, MR, MADDR1..4, DATAIN, DOUT1..4)
// Reads are zero-latency, so the storage is a register array rather than
// a synchronous-read RAM.
// -----------------------------------------------------------------------------
module data_ctrl_dm
  import data_ctrl_dm_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  data_ctrl_dm_if.slave  bus
);

  word_t mem_q   [DEPTH];
  addr_t maddr   [NUM_LANES];
  word_t wdata   [NUM_LANES];
  word_t rd_word [NUM_LANES];
  word_t dout    [NUM_LANES];

  assign maddr[0] = bus.MADDR1;
  assign maddr[1] = bus.MADDR2;
  assign maddr[2] = bus.MADDR3;
  assign maddr[3] = bus.MADDR4;

  assign bus.DOUT1 = dout[0];
  assign bus.DOUT2 = dout[1];
  assign bus.DOUT3 = dout[2];
  assign bus.DOUT4 = dout[3];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign wdata[gi]   = bus.DATAIN[gi*DW +: DW];
      // Low bits only; the read port masks out-of-range addresses.
      assign rd_word[gi] = mem_q[maddr[gi][AW-1:0]];

      data_read_port u_read_port (
        .addr_i  (maddr[gi]),
        .rd_en_i (bus.MR[gi]),
        .word_i  (rd_word[gi]),
        .dout_o  (dout[gi])
      );
    end
  endgenerate

  // Lanes are applied in ascending order, so on an address collision the
  // last (highest-numbered) lane's assignment is the one that sticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned a = 0; a < DEPTH; a++) begin
        mem_q[AW'(a)] <= init_word(a);
      end
    end else if (bus.MEMWRITE) begin
      for (int unsigned l = 0; l < NUM_LANES; l++) begin
        if (addr_in_range(maddr[LANE_W'(l)])) begin
          mem_q[maddr[LANE_W'(l)][AW-1:0]] <= wdata[LANE_W'(l)];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_ctrl_dm.sv
// -----------------------------------------------------------------------------
// tb_data_ctrl_dm
// Table of read vectors against the reset image, hand-written write /
// collision / reset sequences, then randomized traffic checked against an
// array model of the memory.
// -----------------------------------------------------------------------------
module tb_data_ctrl_dm;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  data_ctrl_dm_if bus ();

  data_ctrl_dm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]       mr;
    logic [3:0][15:0] a;
    logic [3:0][15:0] e;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs [NVEC];

  logic [15:0] ref_mem [64];

  function automatic vec_t mkv(logic [3:0] mr,
                               logic [15:0] a1, logic [15:0] a2, logic [15:0] a3, logic [15:0] a4,
                               logic [15:0] e1, logic [15:0] e2, logic [15:0] e3, logic [15:0] e4);
    vec_t v;
    v.mr = mr;
    v.a[0] = a1; v.a[1] = a2; v.a[2] = a3; v.a[3] = a4;
    v.e[0] = e1; v.e[1] = e2; v.e[2] = e3; v.e[3] = e4;
    return v;
  endfunction

  // Reset image written out as matrices: M1 (4x2) at rows 0,8,16,24 cols 0/1,
  // M2 (4x2) at the same rows, cols 4/5.
  task automatic model_reset();
    int m1 [4][2];
    int m2 [4][2];
    m1 = '{'{1, 5}, '{2, 6}, '{3, 7}, '{4, 8}};
    m2 = '{'{1, 2}, '{5, 6}, '{9, 10}, '{13, 14}};
    for (int i = 0; i < 64; i++) ref_mem[i] = 16'h0000;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 2; c++) begin
        ref_mem[r*8 + c]     = 16'(m1[r][c]);
        ref_mem[r*8 + 4 + c] = 16'(m2[r][c]);
      end
    end
  endtask

  function automatic logic [15:0] model_read(logic en, logic [15:0] a);
    if (en && a < 16'd64) return ref_mem[a[5:0]];
    return 16'h0000;
  endfunction

  task automatic model_write(logic [15:0] a1, logic [15:0] a2, logic [15:0] a3,
                             logic [15:0] a4, logic [63:0] d);
    logic [15:0] aa [4];
    aa = '{a1, a2, a3, a4};
    for (int l = 0; l < 4; l++) begin
      if (aa[l] < 16'd64) ref_mem[aa[l][5:0]] = d[l*16 +: 16];
    end
  endtask

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic chk4(string name, logic [15:0] e1, logic [15:0] e2,
                      logic [15:0] e3, logic [15:0] e4);
    chk({name, ".DOUT1"}, bus.DOUT1, e1);
    chk({name, ".DOUT2"}, bus.DOUT2, e2);
    chk({name, ".DOUT3"}, bus.DOUT3, e3);
    chk({name, ".DOUT4"}, bus.DOUT4, e4);
  endtask

  task automatic drive(logic we, logic [3:0] mr, logic [15:0] a1, logic [15:0] a2,
                       logic [15:0] a3, logic [15:0] a4, logic [63:0] d);
    bus.MEMWRITE = we;
    bus.MR       = mr;
    bus.MADDR1   = a1;
    bus.MADDR2   = a2;
    bus.MADDR3   = a3;
    bus.MADDR4   = a4;
    bus.DATAIN   = d;
  endtask

  initial begin
    logic        we;
    logic [3:0]  mr;
    logic [15:0] ra [4];
    logic [63:0] d;

    pass_cnt  = 0;
    total_cnt = 0;
    rst_n     = 1'b0;
    drive(1'b0, 4'b0000, 16'd0, 16'd1, 16'd4, 16'd5, 64'd0);

    vecs[0] = mkv(4'b0000, 16'd0, 16'd1, 16'd4, 16'd5,     16'd0, 16'd0, 16'd0, 16'd0);
    vecs[1] = mkv(4'b1111, 16'd0, 16'd0, 16'd1, 16'd1,     16'd1, 16'd1, 16'd5, 16'd5);
    vecs[2] = mkv(4'b1111, 16'd4, 16'd5, 16'd4, 16'd5,     16'd1, 16'd2, 16'd1, 16'd2);
    vecs[3] = mkv(4'b1111, 16'd20, 16'd21, 16'd20, 16'd21, 16'd9, 16'd10, 16'd9, 16'd10);
    vecs[4] = mkv(4'b1111, 16'd28, 16'd29, 16'd28, 16'd29, 16'd13, 16'd14, 16'd13, 16'd14);
    vecs[5] = mkv(4'b1111, 16'd8, 16'd9, 16'd16, 16'd17,   16'd2, 16'd6, 16'd3, 16'd7);
    vecs[6] = mkv(4'b1111, 16'd24, 16'd25, 16'd12, 16'd13, 16'd4, 16'd8, 16'd5, 16'd6);
    // Out of range: low 6 bits alias to words 0/1/4/5 which are non-zero.
    vecs[7] = mkv(4'b1111, 16'd64, 16'h0101, 16'h8004, 16'hFFC5, 16'd0, 16'd0, 16'd0, 16'd0);
    vecs[8] = mkv(4'b0101, 16'd1, 16'd1, 16'd1, 16'd1,     16'd5, 16'd0, 16'd5, 16'd0);
    vecs[9] = mkv(4'b1010, 16'd63, 16'd12, 16'd2, 16'd29,  16'd0, 16'd5, 16'd0, 16'd14);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // ---- table-driven reads of the reset image (no clock edge needed) ----
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(1'b0, vecs[i].mr, vecs[i].a[0], vecs[i].a[1], vecs[i].a[2], vecs[i].a[3], 64'd0);
      #1;
      chk4($sformatf("vec%0d", i), vecs[i].e[0], vecs[i].e[1], vecs[i].e[2], vecs[i].e[3]);
    end

    // ---- four-lane write with read-during-write ----
    @(negedge clk);
    drive(1'b1, 4'b1111, 16'd40, 16'd41, 16'd42, 16'd43, 64'h0004_0003_0002_0001);
    #1;
    chk4("wr_before_edge", 16'd0, 16'd0, 16'd0, 16'd0);
    @(posedge clk);
    #1;
    chk4("wr_after_edge", 16'd1, 16'd2, 16'd3, 16'd4);
    @(negedge clk);
    bus.MEMWRITE = 1'b0;
    #1;
    chk4("wr_readback", 16'd1, 16'd2, 16'd3, 16'd4);

    // ---- collision: lane 4 must win ----
    @(negedge clk);
    drive(1'b1, 4'b1111, 16'd50, 16'd50, 16'd50, 16'd50, 64'hDDDD_CCCC_BBBB_AAAA);
    @(posedge clk);
    #1;
    @(negedge clk);
    bus.MEMWRITE = 1'b0;
    #1;
    chk4("collision", 16'hDDDD, 16'hDDDD, 16'hDDDD, 16'hDDDD);

    // ---- writes ignore MR; out-of-range lanes are dropped ----
    @(negedge clk);
    drive(1'b1, 4'b0000, 16'd60, 16'h0043, 16'd61, 16'h1002, 64'h2222_3333_4444_5555);
    @(posedge clk);
    #1;
    chk4("wr_mr0_dout", 16'd0, 16'd0, 16'd0, 16'd0);
    @(negedge clk);
    drive(1'b0, 4'b1111, 16'd60, 16'd3, 16'd61, 16'd2, 64'd0);
    #1;
    chk4("wr_mr0_oob", 16'h5555, 16'd0, 16'h3333, 16'd0);

    // ---- overwrite word 0, then asynchronous reset mid-write ----
    @(negedge clk);
    drive(1'b1, 4'b1111, 16'd0, 16'd0, 16'd0, 16'd0, {4{16'hFFFF}});
    @(posedge clk);
    #1;
    chk4("ovr0", 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    #2;
    rst_n = 1'b0;          // between edges, write strobe still high
    #1;
    chk4("async_rst", 16'd1, 16'd1, 16'd1, 16'd1);
    @(posedge clk);        // edge while in reset must not write
    #1;
    chk4("rst_hold", 16'd1, 16'd1, 16'd1, 16'd1);
    @(negedge clk);
    bus.MEMWRITE = 1'b0;
    rst_n = 1'b1;
    drive(1'b0, 4'b0101, 16'd0, 16'd0, 16'd40, 16'd0, 64'd0);
    #1;
    chk4("post_rst_mr0101", 16'd1, 16'd0, 16'd0, 16'd0);

    // ---- randomized traffic against the array model ----
    model_reset();
    for (int it = 0; it < 400; it++) begin
      @(negedge clk);
      we = 1'($urandom_range(0, 1));
      mr = 4'($urandom);
      for (int l = 0; l < 4; l++) begin
        case ($urandom_range(0, 3))
          0:       ra[l] = 16'($urandom_range(48, 51));   // collision pool
          1:       ra[l] = 16'($urandom);                 // mostly out of range
          default: ra[l] = 16'($urandom_range(0, 70));
        endcase
      end
      d = {32'($urandom), 32'($urandom)};
      drive(we, mr, ra[0], ra[1], ra[2], ra[3], d);
      #1;
      chk4($sformatf("rnd%0d_pre", it),
           model_read(mr[0], ra[0]), model_read(mr[1], ra[1]),
           model_read(mr[2], ra[2]), model_read(mr[3], ra[3]));
      @(posedge clk);
      if (we) model_write(ra[0], ra[1], ra[2], ra[3], d);
      #1;
      chk4($sformatf("rnd%0d_post", it),
           model_read(mr[0], ra[0]), model_read(mr[1], ra[1]),
           model_read(mr[2], ra[2]), model_read(mr[3], ra[3]));
    end

    // Sweep every word once so stale corruption anywhere is caught.
    for (int a = 0; a < 64; a += 4) begin
      @(negedge clk);
      drive(1'b0, 4'b1111, 16'(a), 16'(a + 1), 16'(a + 2), 16'(a + 3), 64'd0);
      #1;
      chk4($sformatf("sweep%0d", a), ref_mem[a], ref_mem[a + 1], ref_mem[a + 2], ref_mem[a + 3]);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/data_ctrl_dm.md
Name: data_ctrl_dm

Overview:
- Shared data memory plus load/store controller for a four-core processor cluster.
- Each core has its own read port: address in, 16-bit data out, gated by a per-core read strobe.
- One common write strobe stores up to four 16-bit words per clock, one lane per core.
- On reset the memory holds a fixed image containing two interleaved 4x2 operand matrices (M1, M2) used by the matrix-multiply program.

Parameters:
- DEPTH, 64, number of 16-bit memory words; valid addresses are 0..DEPTH-1.
- AW, 6, index width used internally, equal to log2(DEPTH).
- DW, 16, data word width.

Ports:
- clk  input  1  system clock; all writes take effect on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- MEMWRITE  input  1  write strobe, common to all four lanes.
- MR  input  4  per-core read enables; MR[i] serves core i+1.
- MADDR1..MADDR4  input  16 each  word address for cores 1..4.
- DATAIN  input  64  write data; lane i (core i+1) is bits [16i+15:16i].
- DOUT1..DOUT4  output  16 each  read data for cores 1..4.

Behaviour:
- Storage: array of DEPTH x 16-bit registers.
- Reset (rst_n low, asynchronous, any time including mid-write) loads the initial image below.
- Initial image, address=value:
  - M1 elements: 0=1, 1=5, 8=2, 9=6, 16=3, 17=7, 24=4, 25=8.
  - M2 elements: 4=1, 5=2, 12=5, 13=6, 20=9, 21=10, 28=13, 29=14.
  - All other words = 0.
- Read path is purely combinational, with zero latency:
  - DOUTi = mem[MADDRi] when MR[i-1]=1.
  - DOUTi = 16'h0000 when MR[i-1]=0.
  - DOUTi = 0 when MADDRi >= DEPTH.
- Ports are independent. Any number of cores may read the same address simultaneously, and all receive the same word.
- Write path:
  - On the rising clk edge with MEMWRITE=1 and rst_n=1, for each lane i=1..4, mem[MADDRi] <= DATAIN lane i.
  - Writes are not gated by MR.
  - A lane whose address is >= DEPTH is ignored.
- Write collisions (two or more lanes at the same address): the highest-numbered lane wins.
- Read during write: DOUT shows the old value until the edge, then the new value in the same cycle after the edge.
- MADDR bits above AW must all be zero for a valid access; otherwise the address is out of range.
- No handshake or busy signal exists; every request completes immediately.

Decomposition:
- Shared package holds:
  - DW and the lane count (4).
  - The initial-image constant, as a function returning the reset value for an address.
- The module itself holds the storage array, the reset/write process, and four read muxes.
- Sub-module: data_read_port, one instance per core, implementing the MR gating and the range check on top of the shared array read.

Test Plan:
- Reset then MR=0000 with any addresses -> DOUT1..4 = 0.
- MADDR=(0,0,1,1), MR=1111 -> DOUT=(1,1,5,5) within the same cycle, no clock edge required.
- MADDR=(4,5,4,5), then (20,21,20,21), then (28,29,28,29), MR=1111 -> (1,2,1,2), (9,10,9,10), (13,14,13,14).
- MEMWRITE=1, MADDR=(40,41,42,43), DATAIN=64'h0004_0003_0002_0001, one edge; then read -> DOUT=(1,2,3,4).
- Collision: all MADDR=50, DATAIN lanes 1..4 = A,B,C,D -> mem[50]=D.
- Mid-test rst_n pulse after overwriting address 0 with 16'hFFFF -> address 0 reads 1 immediately after reset; MR=0101 -> DOUT2=DOUT4=0.
